// File: rtl/oclib_pkg.sv
// Shared CSR bus types and constants for the oclib CSR fabric.
package oclib_pkg;

  localparam int unsigned CsrInitTimeoutDefault = 1024;
  localparam logic [31:0] BcBlockIdAny          = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] toblock;
    logic [3:0]  space;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        write;
    logic        read;
  } csr_32_noc_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_noc_fb_s;

endpackage

// File: rtl/oclib_csr_initiator.sv
// CSR bus master: turns one accepted command into one CSR strobe and reports
// the result (or a timeout) on a single-cycle response strobe.
module oclib_csr_initiator
  import oclib_pkg::*;
#(
  parameter type         CsrType       = csr_32_noc_s,
  parameter type         CsrFbType     = csr_32_noc_fb_s,
  parameter int unsigned TimeoutCycles = CsrInitTimeoutDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic [31:0] cmdBlock,
  input  logic [3:0]  cmdSpace,
  input  logic [31:0] cmdAddress,
  input  logic [31:0] cmdWdata,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspError,
  output logic        rspTimeout,
  output CsrType      csr,
  input  CsrFbType    csrFb
);

  localparam int unsigned TimerW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [TimerW-1:0] TimerMax =
      TimerW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e            state_q, state_d;
  CsrType            csr_q, csr_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    csr_d         = csr_q;
    timer_d       = timer_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      StIdle: begin
        if (cmdValid) begin
          csr_d.toblock = cmdBlock;
          csr_d.space   = cmdSpace;
          csr_d.address = cmdAddress;
          csr_d.wdata   = cmdWdata;
          csr_d.write   = cmdWrite;
          csr_d.read    = !cmdWrite;
          timer_d       = '0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        // ready takes priority over a timeout landing in the same cycle
        if (csrFb.ready) begin
          rsp_data_d    = csr_q.write ? 32'h0 : csrFb.rdata;
          rsp_error_d   = csrFb.error;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          csr_d.write   = 1'b0;
          csr_d.read    = 1'b0;
          state_d       = StDone;
        end else if (TimeoutCycles != 0 && timer_q == TimerMax) begin
          rsp_data_d    = 32'h0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          csr_d.write   = 1'b0;
          csr_d.read    = 1'b0;
          state_d       = StDone;
        end else if (TimeoutCycles != 0) begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      csr_q         <= '0;
      timer_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'h0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      csr_q         <= csr_d;
      timer_q       <= timer_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmdReady   = (state_q == StIdle);
  assign csr        = csr_q;
  assign rspValid   = rsp_valid_q;
  assign rspData    = rsp_data_q;
  assign rspError   = rsp_error_q;
  assign rspTimeout = rsp_timeout_q;

endmodule
